// File: rtl/concurrent_fifo_pkg.sv
// Shared defaults for the single-clock FIFO and its storage array.
package concurrent_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_DEF      = 16;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int PTR_WIDTH_DEF  = ADDR_WIDTH_DEF + 1;

endpackage

// File: rtl/concurrent_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, registered read with enable.
module concurrent_fifo_mem
    import concurrent_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Storage is deliberately left out of reset; only the output register clears.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/concurrent_fifo_async_top.sv
// Single-clock FIFO with full/empty back-pressure; the name is kept for existing instantiations.
module concurrent_fifo_async_top
    import concurrent_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("concurrent_fifo_async_top: DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic             wr_accept;
    logic             rd_accept;

    // MSB is the wrap flag: equal low bits with differing MSBs means a full lap ahead.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

    assign wr_accept = write_en && !full;
    assign rd_accept = read_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_accept);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_accept);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    concurrent_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (write_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (read_data)
    );

endmodule

// File: tb/tb_concurrent_fifo_async_top.sv
// Bench for concurrent_fifo_async_top: directed table, corner sequences, randomized queue model.
module tb_concurrent_fifo_async_top;

    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic [DW-1:0] read_data;
    logic          full;
    logic          empty;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] model_rd = '0;

    concurrent_fifo_async_top #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEP),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .write_en   (write_en),
        .read_en    (read_en),
        .write_data (write_data),
        .read_data  (read_data),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          r;
        logic          w;
        logic          re;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;
        logic          exp_e;
        logic          exp_f;
    } vec_t;

    vec_t vecs [16];

    // Drives one cycle and advances the queue model using the occupancy seen before the edge.
    task automatic step(input logic r, input logic w, input logic re, input logic [DW-1:0] d);
        bit was_full;
        bit was_empty;
        reset      = r;
        write_en   = w;
        read_en    = re;
        write_data = d;
        if (r) begin
            model_q.delete();
            model_rd = '0;
        end else begin
            was_full  = (model_q.size() == DEP);
            was_empty = (model_q.size() == 0);
            if (re && !was_empty) model_rd = model_q.pop_front();
            if (w && !was_full) model_q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_rdata"}, read_data, model_rd);
        chk({tag, "_empty"}, {7'd0, empty}, {7'd0, model_q.size() == 0});
        chk({tag, "_full"},  {7'd0, full},  {7'd0, model_q.size() == DEP});
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'hA1, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'hB2, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'hC3, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hA1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hB2, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hC3, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hC3, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hC3, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hC3, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hC3, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 8'h55, 8'hC3, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h55, 1'b1, 1'b0};

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].r, vecs[i].w, vecs[i].re, vecs[i].d);
            chk($sformatf("vec%0d_rdata", i), read_data, vecs[i].exp_rd);
            chk($sformatf("vec%0d_empty", i), {7'd0, empty}, {7'd0, vecs[i].exp_e});
            chk($sformatf("vec%0d_full", i),  {7'd0, full},  {7'd0, vecs[i].exp_f});
        end

        // Fill to full, overflow attempt, then read+write while full.
        for (int i = 0; i < DEP; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(i));
            chk($sformatf("fill%0d_full", i), {7'd0, full}, {7'd0, i == DEP - 1});
        end
        step(1'b0, 1'b1, 1'b0, 8'hAA);
        chk("overflow_full", {7'd0, full}, 8'd1);
        chk("overflow_rdata", read_data, 8'h55);
        step(1'b0, 1'b1, 1'b1, 8'h77);
        chk("full_rw_rdata", read_data, 8'h00);
        chk("full_rw_full", {7'd0, full}, 8'd0);
        for (int i = 1; i < DEP; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk($sformatf("drain%0d_rdata", i), read_data, 8'(i));
        end
        chk("drain_empty", {7'd0, empty}, 8'd1);

        // Half full: simultaneous read+write keeps occupancy.
        for (int i = 0; i < DEP / 2; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        step(1'b0, 1'b1, 1'b1, 8'h99);
        chk("half_rw_rdata", read_data, 8'h10);
        chk("half_rw_occ", 8'(model_q.size()), 8'(DEP / 2));
        chk_model("half_rw");
        while (model_q.size() != 0) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk_model("half_drain");
        end

        // Stream across the pointer wrap with interleaved reads.
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 1'(i % 2), 8'(8'h40 + i));
            chk_model("wrap");
        end
        for (int i = 0; i < 2 * DEP && model_q.size() != 0; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk_model("wrap_drain");
        end
        chk("wrap_empty", {7'd0, empty}, 8'd1);

        // Reset with words stored; only post-reset data may come out.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hD0 + i));
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("midrst_empty", {7'd0, empty}, 8'd1);
        chk("midrst_rdata", read_data, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'hE1);
        step(1'b0, 1'b1, 1'b0, 8'hE2);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("midrst_rd1", read_data, 8'hE1);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("midrst_rd2", read_data, 8'hE2);
        chk("midrst_end_empty", {7'd0, empty}, 8'd1);

        // Randomized traffic, biased per phase towards filling or draining.
        for (int i = 0; i < 600; i++) begin
            logic r;
            logic w;
            logic re;
            r  = ($urandom_range(0, 99) == 0);
            w  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 30));
            re = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70));
            step(r, w, re, 8'($urandom));
            chk_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
